// File: rtl/spi_imem_loader.sv
// spi_imem_loader
//   Boot loader between the SPI slave byte engine and the IMEM port.
//   Command 0x02 streams LSB-first 32-bit words into IMEM until the word
//   0xFFFFFFFF arrives. Command 0x01 reads words back: the host sends a
//   4-byte byte-address, and the fetched word is shifted out during the
//   next address.
//
// Ports
//   i_clk, globalRSTN           clock, async active-low reset
//   i_prog                      programming mode enable
//   i_cs_n                      chip select (synchronised), active low
//   i_rx_valid, i_rx_byte       received byte strobe/data
//   o_tx_byte                   byte loaded by the slave at the next transfer
//   o_mem_we/re/addr/wdata      IMEM port, i_mem_rdata one cycle after re
//   o_word_count                words written by the last write stream
//   o_boot_done                 terminator received
//   o_err                       sticky, write attempted beyond DEPTH
//
// state      | meaning
// -----------+----------------------------------------------------
// IDLE       | waiting for CS fall while programming
// CMD        | waiting for the command byte
// WR_COLLECT | assembling a write word, byte loopback on tx
// WR_COMMIT  | writing the assembled word (or terminating / error)
// DONE       | terminator seen, ignoring bytes until CS rises
// DISCARD    | unknown command, ignoring bytes until CS rises
// RD_ADDR    | assembling a byte-address, shifting out last response
// RD_FETCH   | IMEM read strobe
// RD_LATCH   | capture read data into response register

module spi_imem_loader #(
  parameter int          ADDR_W   = 9,
  parameter int          DEPTH    = 512,
  parameter logic [7:0]  CMD_WR   = 8'h02,
  parameter logic [7:0]  CMD_RD   = 8'h01,
  parameter logic [31:0] END_WORD = 32'hFFFFFFFF
) (
  input  logic              i_clk,
  input  logic              globalRSTN,
  input  logic              i_prog,
  input  logic              i_cs_n,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_byte,
  output logic [7:0]        o_tx_byte,
  output logic              o_mem_we,
  output logic              o_mem_re,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata,
  output logic [ADDR_W:0]   o_word_count,
  output logic              o_boot_done,
  output logic              o_err
);

  typedef enum logic [3:0] {
    IDLE, CMD, WR_COLLECT, WR_COMMIT, DONE, DISCARD, RD_ADDR, RD_FETCH, RD_LATCH
  } state_t;

  // address register is one bit wider so it can sit at DEPTH after overflow
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic              cs_n_q;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       resp_q, resp_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        tx_q, tx_d;
  logic [1:0]        nxt_byte;
  logic              cs_fall, cs_rise;

  assign cs_fall  = cs_n_q & ~i_cs_n;
  assign cs_rise  = ~cs_n_q & i_cs_n;
  assign nxt_byte = byte_cnt_q + 2'd1;

  always_ff @(posedge i_clk or negedge globalRSTN) begin
    if (!globalRSTN) begin
      state_q    <= IDLE;
      cs_n_q     <= 1'b1;
      byte_cnt_q <= '0;
      word_q     <= '0;
      resp_q     <= '0;
      addr_q     <= '0;
      wc_q       <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tx_q       <= '0;
    end else begin
      state_q    <= state_d;
      cs_n_q     <= i_cs_n;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      resp_q     <= resp_d;
      addr_q     <= addr_d;
      wc_q       <= wc_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    resp_d      = resp_q;
    addr_d      = addr_q;
    wc_d        = wc_q;
    done_d      = done_q;
    err_d       = err_q;
    tx_d        = tx_q;
    o_mem_we    = 1'b0;
    o_mem_re    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;

    if (!i_prog) begin
      state_d    = IDLE;
      byte_cnt_d = '0;
      word_d     = '0;
    end else if (cs_rise) begin
      // a byte landing on the same edge as the CS rise is dropped here
      state_d    = IDLE;
      byte_cnt_d = '0;
      word_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_d = CMD;
            tx_d    = '0;
          end
        end
        CMD: begin
          if (i_rx_valid) begin
            byte_cnt_d = '0;
            word_d     = '0;
            if (i_rx_byte == CMD_WR) begin
              state_d = WR_COLLECT;
              addr_d  = '0;
              wc_d    = '0;
              done_d  = 1'b0;
              err_d   = 1'b0;
            end else if (i_rx_byte == CMD_RD) begin
              state_d = RD_ADDR;
              resp_d  = '0;
              tx_d    = '0;
            end else begin
              state_d = DISCARD;
            end
          end
        end
        WR_COLLECT: begin
          if (i_rx_valid) begin
            word_d[{byte_cnt_q, 3'b000} +: 8] = i_rx_byte;
            tx_d       = i_rx_byte;
            byte_cnt_d = nxt_byte;
            if (byte_cnt_q == 2'd3) state_d = WR_COMMIT;
          end
        end
        WR_COMMIT: begin
          state_d = WR_COLLECT;
          if (word_q == END_WORD) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else if (addr_q < DEPTH_C) begin
            o_mem_we    = 1'b1;
            o_mem_addr  = addr_q[ADDR_W-1:0];
            o_mem_wdata = word_q;
            addr_d      = addr_q + ONE_C;
            wc_d        = wc_q + ONE_C;
          end else begin
            err_d = 1'b1;
          end
        end
        DONE, DISCARD: begin
        end
        RD_ADDR: begin
          if (i_rx_valid) begin
            word_d[{byte_cnt_q, 3'b000} +: 8] = i_rx_byte;
            // present the next response byte for the following transfer
            tx_d       = resp_q[{nxt_byte, 3'b000} +: 8];
            byte_cnt_d = nxt_byte;
            if (byte_cnt_q == 2'd3) state_d = RD_FETCH;
          end
        end
        RD_FETCH: begin
          o_mem_re   = 1'b1;
          o_mem_addr = word_q[ADDR_W+1:2];
          state_d    = RD_LATCH;
        end
        RD_LATCH: begin
          resp_d  = i_mem_rdata;
          tx_d    = i_mem_rdata[7:0];
          state_d = RD_ADDR;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign o_tx_byte    = tx_q;
  assign o_word_count = wc_q;
  assign o_boot_done  = done_q;
  assign o_err        = err_q;

  // SPI byte time guarantees no byte lands in the single-cycle states
  a_no_rx_busy: assert property (@(posedge i_clk) disable iff (!globalRSTN)
    !(i_rx_valid && (state_q == WR_COMMIT || state_q == RD_FETCH || state_q == RD_LATCH)));

endmodule

// File: tb/tb_spi_imem_loader.sv
module tb_spi_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prog = 1'b0;
  logic        prog_s = 1'b0;
  logic        cs_n = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;

  logic [7:0]  tx, tx_s;
  logic        we, re, we_s, re_s;
  logic [8:0]  maddr;
  logic [1:0]  maddr_s;
  logic [31:0] wdata, wdata_s;
  logic [31:0] rdata = 32'h0;
  logic [9:0]  wc;
  logic [2:0]  wc_s;
  logic        done, done_s, err, err_s;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        is_we;
    logic [8:0]  addr;
    logic [31:0] data;
  } ev_t;
  ev_t exp_q[$];
  ev_t exp_s[$];

  logic [31:0] mem [512];

  always #5 clk = ~clk;

  spi_imem_loader dut (
    .i_clk(clk), .globalRSTN(rst_n), .i_prog(prog), .i_cs_n(cs_n),
    .i_rx_valid(rx_valid), .i_rx_byte(rx_byte), .o_tx_byte(tx),
    .o_mem_we(we), .o_mem_re(re), .o_mem_addr(maddr), .o_mem_wdata(wdata),
    .i_mem_rdata(rdata), .o_word_count(wc), .o_boot_done(done), .o_err(err)
  );

  spi_imem_loader #(.ADDR_W(2), .DEPTH(4)) dut_s (
    .i_clk(clk), .globalRSTN(rst_n), .i_prog(prog_s), .i_cs_n(cs_n),
    .i_rx_valid(rx_valid), .i_rx_byte(rx_byte), .o_tx_byte(tx_s),
    .o_mem_we(we_s), .o_mem_re(re_s), .o_mem_addr(maddr_s), .o_mem_wdata(wdata_s),
    .i_mem_rdata(32'h0), .o_word_count(wc_s), .o_boot_done(done_s), .o_err(err_s)
  );

  // IMEM model for the main instance
  always @(posedge clk) begin
    if (re) rdata <= mem[maddr];
    if (we) mem[maddr] <= wdata;
  end

  // scoreboard monitor: main instance
  always @(negedge clk) begin
    ev_t e;
    if (we || re) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected we=%0b re=%0b addr=%0d wdata=%h", we, re, maddr, wdata);
      end else begin
        e = exp_q.pop_front();
        if (we !== e.is_we || re !== !e.is_we || maddr !== e.addr || (e.is_we && wdata !== e.data)) begin
          errors++;
          $display("FAIL strobe actual we=%0b re=%0b addr=%0d data=%h required we=%0b addr=%0d data=%h",
                   we, re, maddr, wdata, e.is_we, e.addr, e.data);
        end
      end
    end
  end

  // scoreboard monitor: DEPTH=4 instance
  always @(negedge clk) begin
    ev_t e;
    if (we_s || re_s) begin
      checks++;
      if (exp_s.size() == 0) begin
        errors++;
        $display("FAIL strobe_s_unexpected we=%0b re=%0b addr=%0d wdata=%h", we_s, re_s, maddr_s, wdata_s);
      end else begin
        e = exp_s.pop_front();
        if (we_s !== e.is_we || re_s !== !e.is_we || {7'd0, maddr_s} !== e.addr || (e.is_we && wdata_s !== e.data)) begin
          errors++;
          $display("FAIL strobe_s actual we=%0b re=%0b addr=%0d data=%h required we=%0b addr=%0d data=%h",
                   we_s, re_s, maddr_s, wdata_s, e.is_we, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [8:0] a, input logic [31:0] d);
    exp_q.push_back('{is_we: 1'b1, addr: a, data: d});
  endtask

  task automatic push_rd(input logic [8:0] a);
    exp_q.push_back('{is_we: 1'b0, addr: a, data: 32'h0});
  endtask

  // returns one cycle after the rx pulse, i.e. in the commit/fetch cycle
  task automatic send(input logic [7:0] b);
    repeat (6) @(posedge clk);
    #1 rx_byte = b; rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send(w[8*k +: 8]);
  endtask

  // read-back address; checks the tx byte the slave would load before each transfer
  task automatic send_rd(input logic [31:0] a, input logic [31:0] exp_resp);
    for (int k = 0; k < 4; k++) begin
      repeat (3) @(posedge clk);
      #1 chk("rd_tx_byte", {24'd0, tx}, {24'd0, exp_resp[8*k +: 8]});
      send(a[8*k +: 8]);
    end
  endtask

  task automatic cs_lo();
    @(posedge clk); #1 cs_n = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic cs_hi();
    repeat (4) @(posedge clk); #1 cs_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", {24'd0, tx}, 32'h0);
    chk("rst_mem_strobes", {30'd0, we, re}, 32'h0);
    chk("rst_word_count", {22'd0, wc}, 32'h0);
    chk("rst_boot_done", {31'd0, done}, 32'h0);
    chk("rst_err", {31'd0, err}, 32'h0);
    rst_n = 1'b1;
    prog  = 1'b1;
    repeat (2) @(posedge clk);

    // 1: write stream
    cs_lo();
    send(8'h02);
    push_wr(9'd0, 32'h00000093);
    send_word(32'h00000093);
    chk("wr_latency_we", {31'd0, we}, 32'h1);
    chk("wr_loopback_tx", {24'd0, tx}, 32'h0);
    push_wr(9'd1, 32'h00100113);
    send_word(32'h00100113);
    chk("wr_loopback_tx2", {24'd0, tx}, 32'h00);
    chk("done_before_end", {31'd0, done}, 32'h0);
    send_word(32'hFFFFFFFF);
    repeat (2) @(posedge clk); #1;
    chk("wr_word_count", {22'd0, wc}, 32'd2);
    chk("wr_boot_done", {31'd0, done}, 32'h1);
    chk("wr_err", {31'd0, err}, 32'h0);
    chk("wr_loopback_ff", {24'd0, tx}, 32'hFF);
    cs_hi();
    chk("wr_done_held_cs", {31'd0, done}, 32'h1);

    // 2: read-back
    cs_lo();
    chk("rd_tx_cleared", {24'd0, tx}, 32'h0);
    send(8'h01);
    push_rd(9'd0);
    send_rd(32'd0, 32'h00000000);
    push_rd(9'd1);
    send_rd(32'd4, 32'h00000093);
    push_rd(9'd2);
    send_rd(32'd8, 32'h00100113);
    repeat (3) @(posedge clk); #1;
    chk("rd_tx_last", {24'd0, tx}, 32'h0);
    cs_hi();
    chk("rd_word_count_kept", {22'd0, wc}, 32'd2);
    chk("rd_boot_done_kept", {31'd0, done}, 32'h1);
    chk("rd_mem0_intact", mem[0], 32'h00000093);

    // 3: abort mid-word
    cs_lo();
    send(8'h02);
    send(8'hAA);
    send(8'hBB);
    cs_hi();
    chk("abort_done_cleared", {31'd0, done}, 32'h0);
    cs_lo();
    send(8'h02);
    push_wr(9'd0, 32'h11223344);
    send_word(32'h11223344);
    cs_hi();
    chk("abort_word_count", {22'd0, wc}, 32'd1);
    chk("abort_mem0", mem[0], 32'h11223344);

    // 4: overflow on the DEPTH=4 instance, main instance out of programming mode
    prog   = 1'b0;
    prog_s = 1'b1;
    cs_lo();
    send(8'h02);
    for (int i = 0; i < 4; i++) begin
      exp_s.push_back('{is_we: 1'b1, addr: 9'(i), data: 32'hA0000000 + 32'(i)});
      send_word(32'hA0000000 + 32'(i));
    end
    repeat (2) @(posedge clk); #1;
    chk("ovf_err_before", {31'd0, err_s}, 32'h0);
    chk("ovf_count_4", {29'd0, wc_s}, 32'd4);
    send_word(32'hA0000004);
    repeat (2) @(posedge clk); #1;
    chk("ovf_err_after", {31'd0, err_s}, 32'h1);
    send_word(32'hFFFFFFFF);
    repeat (2) @(posedge clk); #1;
    chk("ovf_word_count", {29'd0, wc_s}, 32'd4);
    chk("ovf_boot_done", {31'd0, done_s}, 32'h1);
    chk("ovf_err_sticky", {31'd0, err_s}, 32'h1);
    cs_hi();
    chk("prog0_main_count_held", {22'd0, wc}, 32'd1);
    prog_s = 1'b0;
    prog   = 1'b1;

    // 5: bad command
    cs_lo();
    send(8'h55);
    for (int i = 0; i < 8; i++) begin
      send(8'h10 + 8'(i));
      chk("bad_cmd_tx", {24'd0, tx}, 32'h0);
    end
    cs_hi();

    // 6: reset mid-stream, then prog=0
    cs_lo();
    send(8'h02);
    send(8'h11);
    send(8'h22);
    send(8'h77);
    chk("pre_rst_tx", {24'd0, tx}, 32'h77);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tx", {24'd0, tx}, 32'h0);
    chk("async_rst_state_out", {22'd0, wc, done, err}, 32'h0);
    cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cs_lo();
    send(8'h02);
    push_wr(9'd0, 32'hCAFEF00D);
    send_word(32'hCAFEF00D);
    send_word(32'hFFFFFFFF);
    cs_hi();
    chk("post_rst_count", {22'd0, wc}, 32'd1);
    chk("post_rst_done", {31'd0, done}, 32'h1);
    prog = 1'b0;
    cs_lo();
    send(8'h02);
    send_word(32'h12345678);
    send_word(32'hFFFFFFFF);
    cs_hi();
    chk("prog0_done_held", {31'd0, done}, 32'h1);
    chk("prog0_count_held", {22'd0, wc}, 32'd1);

    repeat (10) @(posedge clk);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("exp_s_drained", exp_s.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
